id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the stall-event counter.
REQ-002 SHALL have port clock, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port ID_Instr, input, 32, decode-stage instruction; rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0].
REQ-005 SHALL have ports ReadData1 and ReadData2, input, 32 each, register file read data for rs and rt.
REQ-006 SHALL have ports WB_RegWrite (1), WB_WriteReg (5) and WB_WriteData (32), all inputs, the write-back stage write request.
REQ-007 SHALL have control inputs ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg, ID_ALUSrc and ID_RegDst (1 each) and ID_ALUOp (2).
REQ-008 SHALL have port Flush, input, 1, branch-taken discard of the decode instruction.
REQ-009 SHALL have port Stall, output, 1, combinational hold request to the PC and the IF/ID register.
REQ-010 SHALL have registered outputs EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg, EX_ALUSrc, EX_ALUOp (2), EX_ReadData1 (32), EX_ReadData2 (32), EX_Imm (32), EX_Rs (5), EX_Rt (5), EX_WriteReg (5) and EX_Valid (1).
REQ-011 SHALL have port StallCount, output, CNT_W, registered count of load-use stall cycles.

Function
REQ-012 SHALL assert Stall when EX_Valid=1, EX_MemRead=1, EX_Rt!=0 and EX_Rt equals ID rs or ID rt, and Flush=0.
REQ-013 SHALL force Stall=0 whenever Flush=1, because Flush has priority.
REQ-014 SHALL load a bubble on a clock edge with Stall=1 or Flush=1: all EX control outputs 0, EX_Valid=0, and data/index outputs don't-care but deterministic (cleared to 0).
REQ-015 SHALL otherwise capture the decode values into the EX registers on every edge with 1-cycle latency, setting EX_Valid=1.
REQ-016 SHALL select the captured rs operand with priority: rs==0 -> 0; else WB bypass match -> WB_WriteData; else ReadData1.
REQ-017 SHALL select the captured rt operand by the same rule applied to rt and ReadData2.
REQ-018 SHALL define a WB bypass match as WB_RegWrite=1, WB_WriteReg!=0 and WB_WriteReg equal to the source index.
REQ-019 SHALL set EX_Imm to imm sign-extended to 32 bits (bit 15 replicated).
REQ-020 SHALL set EX_WriteReg to rd when ID_RegDst=1 and to rt otherwise.
REQ-021 SHALL set EX_Rs and EX_Rt to the ID rs and rt fields.
REQ-022 SHALL increment StallCount by 1 on each edge with Stall=1, saturating at all-ones with no wrap.
REQ-023 SHALL hold a stall for exactly one cycle per load-use hazard, since the inserted bubble clears EX_MemRead.
REQ-024 SHALL handle Flush and a load-use hazard in the same cycle as a flush: bubble loaded, Stall=0, StallCount unchanged.
REQ-025 SHALL never raise a hazard or bypass on register 0.

Reset
REQ-026 SHALL, while reset_n=0, drive all EX registered outputs, EX_Valid and StallCount to 0 asynchronously.
REQ-027 SHALL keep Stall=0 during reset, because EX_Valid=0.
REQ-028 SHALL resume normal capture on the first rising edge after reset_n deasserts.
REQ-029 SHALL, on reset asserted mid-stall, drop Stall immediately and discard the bubble state.

Verification
REQ-030 SHALL verify plain capture: ID_Instr with rs=3, rt=4, imm=0xFFF0, ReadData1=0x11, ReadData2=0x22, ID_RegWrite=1 -> next cycle EX_ReadData1=0x11, EX_ReadData2=0x22, EX_Imm=0xFFFFFFF0, EX_Valid=1.
REQ-031 SHALL verify load-use: EX holds MemRead=1, EX_Rt=5; ID rs=5 -> Stall=1, next EX_Valid=0 with controls 0, Stall=0 the cycle after, StallCount=1.
REQ-032 SHALL verify WB bypass: WB_RegWrite=1, WB_WriteReg=7, WB_WriteData=0xABCD; ID rt=7, ReadData2=0x0 -> EX_ReadData2=0xABCD; repeat with WB_WriteReg=0 and rt=0 -> EX_ReadData2=0.
REQ-033 SHALL verify flush priority: load-use hazard plus Flush=1 -> Stall=0, bubble loaded, StallCount unchanged.
REQ-034 SHALL verify saturation: CNT_W=2 with 5 hazard stalls -> StallCount=3.
REQ-035 SHALL verify async reset: reset_n pulled low between edges with EX_Valid=1 -> all outputs 0 before the next edge.

Source files
------------

// File: rtl/id_ex_stage.sv
// ============================================================================
// Module   : id_ex_stage
// Purpose  : ID/EX pipeline register with load-use hazard detection,
//            write-back bypass onto the captured operands, flush/stall bubble
//            insertion and a saturating stall-event counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [31:0]      ID_Instr,
  input  logic [31:0]      ReadData1,
  input  logic [31:0]      ReadData2,
  input  logic             WB_RegWrite,
  input  logic [4:0]       WB_WriteReg,
  input  logic [31:0]      WB_WriteData,
  input  logic             ID_RegWrite,
  input  logic             ID_MemRead,
  input  logic             ID_MemWrite,
  input  logic             ID_MemToReg,
  input  logic             ID_ALUSrc,
  input  logic             ID_RegDst,
  input  logic [1:0]       ID_ALUOp,
  input  logic             Flush,
  output logic             Stall,
  output logic             EX_RegWrite,
  output logic             EX_MemRead,
  output logic             EX_MemWrite,
  output logic             EX_MemToReg,
  output logic             EX_ALUSrc,
  output logic [1:0]       EX_ALUOp,
  output logic [31:0]      EX_ReadData1,
  output logic [31:0]      EX_ReadData2,
  output logic [31:0]      EX_Imm,
  output logic [4:0]       EX_Rs,
  output logic [4:0]       EX_Rt,
  output logic [4:0]       EX_WriteReg,
  output logic             EX_Valid,
  output logic [CNT_W-1:0] StallCount
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  // Instruction field extraction
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [15:0] w_imm;
  logic        w_unused_opcode;

  assign w_rs            = ID_Instr[25:21];
  assign w_rt            = ID_Instr[20:16];
  assign w_rd            = ID_Instr[15:11];
  assign w_imm           = ID_Instr[15:0];
  assign w_unused_opcode = ^ID_Instr[31:26];

  // Pipeline registers
  logic             r_regwrite;
  logic             r_memread;
  logic             r_memwrite;
  logic             r_memtoreg;
  logic             r_alusrc;
  logic [1:0]       r_aluop;
  logic [31:0]      r_rd1;
  logic [31:0]      r_rd2;
  logic [31:0]      r_imm;
  logic [4:0]       r_rs;
  logic [4:0]       r_rt;
  logic [4:0]       r_wr;
  logic             r_valid;
  logic [CNT_W-1:0] r_stall_cnt;

  logic        w_stall;
  logic        w_bubble;
  logic [31:0] w_op1;
  logic [31:0] w_op2;

  // Load-use hazard: the load in EX writes a register this instruction reads.
  // Flush wins because the decode instruction is being discarded anyway.
  always_comb begin
    w_stall = 1'b0;
    if (!Flush && r_valid && r_memread && (r_rt != 5'd0) &&
        ((r_rt == w_rs) || (r_rt == w_rt))) begin
      w_stall = 1'b1;
    end
  end

  assign w_bubble = w_stall | Flush;

  // Operand selection: r0 reads as zero, else a same-cycle write-back wins
  // over the (stale) register file read.
  always_comb begin
    w_op1 = ReadData1;
    w_op2 = ReadData2;
    if (w_rs == 5'd0) begin
      w_op1 = 32'd0;
    end else if (WB_RegWrite && (WB_WriteReg != 5'd0) && (WB_WriteReg == w_rs)) begin
      w_op1 = WB_WriteData;
    end
    if (w_rt == 5'd0) begin
      w_op2 = 32'd0;
    end else if (WB_RegWrite && (WB_WriteReg != 5'd0) && (WB_WriteReg == w_rt)) begin
      w_op2 = WB_WriteData;
    end
  end

  // EX register: bubble on stall/flush, otherwise capture decode values
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_alusrc   <= 1'b0;
      r_aluop    <= 2'b00;
      r_rd1      <= 32'd0;
      r_rd2      <= 32'd0;
      r_imm      <= 32'd0;
      r_rs       <= 5'd0;
      r_rt       <= 5'd0;
      r_wr       <= 5'd0;
      r_valid    <= 1'b0;
    end else if (w_bubble) begin
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_alusrc   <= 1'b0;
      r_aluop    <= 2'b00;
      r_rd1      <= 32'd0;
      r_rd2      <= 32'd0;
      r_imm      <= 32'd0;
      r_rs       <= 5'd0;
      r_rt       <= 5'd0;
      r_wr       <= 5'd0;
      r_valid    <= 1'b0;
    end else begin
      r_regwrite <= ID_RegWrite;
      r_memread  <= ID_MemRead;
      r_memwrite <= ID_MemWrite;
      r_memtoreg <= ID_MemToReg;
      r_alusrc   <= ID_ALUSrc;
      r_aluop    <= ID_ALUOp;
      r_rd1      <= w_op1;
      r_rd2      <= w_op2;
      r_imm      <= {{16{w_imm[15]}}, w_imm};
      r_rs       <= w_rs;
      r_rt       <= w_rt;
      r_wr       <= ID_RegDst ? w_rd : w_rt;
      r_valid    <= 1'b1;
    end
  end

  // Saturating count of load-use stall cycles
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != C_CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign Stall        = w_stall;
  assign EX_RegWrite  = r_regwrite;
  assign EX_MemRead   = r_memread;
  assign EX_MemWrite  = r_memwrite;
  assign EX_MemToReg  = r_memtoreg;
  assign EX_ALUSrc    = r_alusrc;
  assign EX_ALUOp     = r_aluop;
  assign EX_ReadData1 = r_rd1;
  assign EX_ReadData2 = r_rd2;
  assign EX_Imm       = r_imm;
  assign EX_Rs        = r_rs;
  assign EX_Rt        = r_rt;
  assign EX_WriteReg  = r_wr;
  assign EX_Valid     = r_valid;
  assign StallCount   = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// Module   : tb_id_ex_stage
// Purpose  : Self-checking bench for id_ex_stage (vector table plus directed
//            saturation and asynchronous-reset sequences).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_ex_stage;

  logic        clock;
  logic        reset_n;
  logic [31:0] ID_Instr;
  logic [31:0] ReadData1, ReadData2;
  logic        WB_RegWrite;
  logic [4:0]  WB_WriteReg;
  logic [31:0] WB_WriteData;
  logic        ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg, ID_ALUSrc, ID_RegDst;
  logic [1:0]  ID_ALUOp;
  logic        Flush;

  logic        Stall;
  logic        EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg, EX_ALUSrc;
  logic [1:0]  EX_ALUOp;
  logic [31:0] EX_ReadData1, EX_ReadData2, EX_Imm;
  logic [4:0]  EX_Rs, EX_Rt, EX_WriteReg;
  logic        EX_Valid;
  logic [15:0] StallCount;

  logic        s_Stall;
  logic        s_RegWrite, s_MemRead, s_MemWrite, s_MemToReg, s_ALUSrc;
  logic [1:0]  s_ALUOp;
  logic [31:0] s_ReadData1, s_ReadData2, s_Imm;
  logic [4:0]  s_Rs, s_Rt, s_WriteReg;
  logic        s_Valid;
  logic [1:0]  s_StallCount;

  id_ex_stage #(.CNT_W(16)) dut (
    .clock(clock), .reset_n(reset_n), .ID_Instr(ID_Instr),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .WB_RegWrite(WB_RegWrite), .WB_WriteReg(WB_WriteReg), .WB_WriteData(WB_WriteData),
    .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite),
    .ID_MemToReg(ID_MemToReg), .ID_ALUSrc(ID_ALUSrc), .ID_RegDst(ID_RegDst),
    .ID_ALUOp(ID_ALUOp), .Flush(Flush), .Stall(Stall),
    .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite),
    .EX_MemToReg(EX_MemToReg), .EX_ALUSrc(EX_ALUSrc), .EX_ALUOp(EX_ALUOp),
    .EX_ReadData1(EX_ReadData1), .EX_ReadData2(EX_ReadData2), .EX_Imm(EX_Imm),
    .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_WriteReg(EX_WriteReg),
    .EX_Valid(EX_Valid), .StallCount(StallCount)
  );

  id_ex_stage #(.CNT_W(2)) dut_sat (
    .clock(clock), .reset_n(reset_n), .ID_Instr(ID_Instr),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .WB_RegWrite(WB_RegWrite), .WB_WriteReg(WB_WriteReg), .WB_WriteData(WB_WriteData),
    .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite),
    .ID_MemToReg(ID_MemToReg), .ID_ALUSrc(ID_ALUSrc), .ID_RegDst(ID_RegDst),
    .ID_ALUOp(ID_ALUOp), .Flush(Flush), .Stall(s_Stall),
    .EX_RegWrite(s_RegWrite), .EX_MemRead(s_MemRead), .EX_MemWrite(s_MemWrite),
    .EX_MemToReg(s_MemToReg), .EX_ALUSrc(s_ALUSrc), .EX_ALUOp(s_ALUOp),
    .EX_ReadData1(s_ReadData1), .EX_ReadData2(s_ReadData2), .EX_Imm(s_Imm),
    .EX_Rs(s_Rs), .EX_Rt(s_Rt), .EX_WriteReg(s_WriteReg),
    .EX_Valid(s_Valid), .StallCount(s_StallCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ctl  = {RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, RegDst, ALUOp[1:0]}
  // xctl = {RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, ALUOp[1:0]}
  typedef struct {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        wbwe;
    logic [4:0]  wbreg;
    logic [31:0] wbdata;
    logic [7:0]  ctl;
    logic        flush;
    logic        x_stall;
    logic        x_valid;
    logic [6:0]  x_ctl;
    logic [31:0] x_rd1;
    logic [31:0] x_rd2;
    logic [31:0] x_imm;
    logic [4:0]  x_rs;
    logic [4:0]  x_rt;
    logic [4:0]  x_wr;
    logic [15:0] x_cnt;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm,
                       input logic [31:0] rd1, input logic [31:0] rd2, input logic wbwe,
                       input logic [4:0] wbreg, input logic [31:0] wbdata,
                       input logic [7:0] ctl, input logic fl);
    ID_Instr     = {6'd0, rs, rt, imm};
    ReadData1    = rd1;
    ReadData2    = rd2;
    WB_RegWrite  = wbwe;
    WB_WriteReg  = wbreg;
    WB_WriteData = wbdata;
    {ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg, ID_ALUSrc, ID_RegDst, ID_ALUOp} = ctl;
    Flush        = fl;
  endtask

  function automatic logic [31:0] sat3(input logic [15:0] c);
    return (c > 16'd3) ? 32'd3 : {16'd0, c};
  endfunction

  initial begin
    logic [15:0] cnt_model;

    // rs  rt  imm      rd1       rd2      we wbreg wbdata    ctl           fl | stall valid xctl        xrd1      xrd2        ximm          xrs xrt xwr cnt
    vecs[0]  = '{5'd3, 5'd4, 16'hFFF0, 32'h11,  32'h22, 1'b0, 5'd0, 32'h0,    8'b1000_0000, 1'b0, 1'b0, 1'b1, 7'b1000000, 32'h11,   32'h22,   32'hFFFFFFF0, 5'd3, 5'd4, 5'd4,  16'd0};
    vecs[1]  = '{5'd1, 5'd5, 16'h0004, 32'h100, 32'h0,  1'b0, 5'd0, 32'h0,    8'b1101_1000, 1'b0, 1'b0, 1'b1, 7'b1101100, 32'h100,  32'h0,    32'h4,        5'd1, 5'd5, 5'd5,  16'd0};
    vecs[2]  = '{5'd5, 5'd6, 16'h1820, 32'h55,  32'h66, 1'b0, 5'd0, 32'h0,    8'b1000_0110, 1'b0, 1'b1, 1'b0, 7'b0000000, 32'h0,    32'h0,    32'h0,        5'd0, 5'd0, 5'd0,  16'd1};
    vecs[3]  = '{5'd5, 5'd6, 16'h1820, 32'h55,  32'h66, 1'b0, 5'd0, 32'h0,    8'b1000_0110, 1'b0, 1'b0, 1'b1, 7'b1000010, 32'h55,   32'h66,   32'h1820,     5'd5, 5'd6, 5'd3,  16'd1};
    vecs[4]  = '{5'd0, 5'd7, 16'h8000, 32'h999, 32'h0,  1'b1, 5'd7, 32'hABCD, 8'b0010_1000, 1'b0, 1'b0, 1'b1, 7'b0010100, 32'h0,    32'hABCD, 32'hFFFF8000, 5'd0, 5'd7, 5'd7,  16'd1};
    vecs[5]  = '{5'd2, 5'd0, 16'h0000, 32'h22,  32'h77, 1'b1, 5'd0, 32'h1234, 8'b0000_0000, 1'b0, 1'b0, 1'b1, 7'b0000000, 32'h22,   32'h0,    32'h0,        5'd2, 5'd0, 5'd0,  16'd1};
    vecs[6]  = '{5'd7, 5'd8, 16'h0010, 32'h1,   32'h2,  1'b1, 5'd7, 32'hCAFE, 8'b1101_1000, 1'b0, 1'b0, 1'b1, 7'b1101100, 32'hCAFE, 32'h2,    32'h10,       5'd7, 5'd8, 5'd8,  16'd1};
    vecs[7]  = '{5'd0, 5'd8, 16'h0000, 32'h3,   32'h4,  1'b0, 5'd0, 32'h0,    8'b1000_0000, 1'b1, 1'b0, 1'b0, 7'b0000000, 32'h0,    32'h0,    32'h0,        5'd0, 5'd0, 5'd0,  16'd1};
    vecs[8]  = '{5'd4, 5'd0, 16'h0000, 32'h44,  32'h0,  1'b0, 5'd4, 32'hDEAD, 8'b0000_0000, 1'b0, 1'b0, 1'b1, 7'b0000000, 32'h44,   32'h0,    32'h0,        5'd4, 5'd0, 5'd0,  16'd1};
    vecs[9]  = '{5'd1, 5'd0, 16'h0000, 32'h5,   32'h0,  1'b0, 5'd0, 32'h0,    8'b1101_1000, 1'b0, 1'b0, 1'b1, 7'b1101100, 32'h5,    32'h0,    32'h0,        5'd1, 5'd0, 5'd0,  16'd1};
    vecs[10] = '{5'd0, 5'd0, 16'h0000, 32'h0,   32'h0,  1'b0, 5'd0, 32'h0,    8'b0000_0000, 1'b0, 1'b0, 1'b1, 7'b0000000, 32'h0,    32'h0,    32'h0,        5'd0, 5'd0, 5'd0,  16'd1};

    // Reset: inputs describe a would-be hazard, but EX is empty
    reset_n = 1'b0;
    drive(5'd5, 5'd5, 16'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 8'b1101_1000, 1'b0);
    repeat (2) @(negedge clock);
    check("reset_valid", {31'd0, EX_Valid}, 32'd0);
    check("reset_stall", {31'd0, Stall}, 32'd0);
    check("reset_cnt", {16'd0, StallCount}, 32'd0);
    check("reset_ctl", {25'd0, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg, EX_ALUSrc, EX_ALUOp}, 32'd0);
    reset_n = 1'b1;

    // Vector table
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rs, vecs[i].rt, vecs[i].imm, vecs[i].rd1, vecs[i].rd2, vecs[i].wbwe,
            vecs[i].wbreg, vecs[i].wbdata, vecs[i].ctl, vecs[i].flush);
      #1;
      check($sformatf("v%0d_stall", i), {31'd0, Stall}, {31'd0, vecs[i].x_stall});
      @(posedge clock);
      #1;
      check($sformatf("v%0d_valid", i), {31'd0, EX_Valid}, {31'd0, vecs[i].x_valid});
      check($sformatf("v%0d_ctl", i),
            {25'd0, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg, EX_ALUSrc, EX_ALUOp},
            {25'd0, vecs[i].x_ctl});
      check($sformatf("v%0d_rd1", i), EX_ReadData1, vecs[i].x_rd1);
      check($sformatf("v%0d_rd2", i), EX_ReadData2, vecs[i].x_rd2);
      check($sformatf("v%0d_imm", i), EX_Imm, vecs[i].x_imm);
      check($sformatf("v%0d_rs", i), {27'd0, EX_Rs}, {27'd0, vecs[i].x_rs});
      check($sformatf("v%0d_rt", i), {27'd0, EX_Rt}, {27'd0, vecs[i].x_rt});
      check($sformatf("v%0d_wr", i), {27'd0, EX_WriteReg}, {27'd0, vecs[i].x_wr});
      check($sformatf("v%0d_cnt", i), {16'd0, StallCount}, {16'd0, vecs[i].x_cnt});
      check($sformatf("v%0d_cnt2", i), {30'd0, s_StallCount}, sat3(vecs[i].x_cnt));
      @(negedge clock);
    end

    // Five more load-use hazards: wide counter keeps counting, 2-bit one saturates
    cnt_model = 16'd1;
    for (int k = 0; k < 5; k++) begin
      drive(5'd1, 5'd5, 16'h0, 32'h1, 32'h2, 1'b0, 5'd0, 32'h0, 8'b1101_1000, 1'b0);
      #1;
      check($sformatf("sat%0d_noload_stall", k), {31'd0, Stall}, 32'd0);
      @(negedge clock);
      drive(5'd5, 5'd9, 16'h0, 32'h3, 32'h4, 1'b0, 5'd0, 32'h0, 8'b1000_0000, 1'b0);
      #1;
      check($sformatf("sat%0d_stall", k), {31'd0, Stall}, 32'd1);
      @(posedge clock);
      #1;
      cnt_model = cnt_model + 16'd1;
      check($sformatf("sat%0d_cnt", k), {16'd0, StallCount}, {16'd0, cnt_model});
      check($sformatf("sat%0d_cnt2", k), {30'd0, s_StallCount}, sat3(cnt_model));
      check($sformatf("sat%0d_bubble", k), {31'd0, EX_Valid}, 32'd0);
      @(negedge clock);
    end
    check("sat_final_cnt2", {30'd0, s_StallCount}, 32'd3);

    // Reset pulled mid-stall, between edges, with a valid load in EX
    drive(5'd1, 5'd5, 16'h0, 32'h1, 32'h2, 1'b0, 5'd0, 32'h0, 8'b1101_1000, 1'b0);
    @(negedge clock);
    drive(5'd5, 5'd9, 16'h0, 32'h3, 32'h4, 1'b0, 5'd0, 32'h0, 8'b1000_0000, 1'b0);
    #1;
    check("areset_pre_valid", {31'd0, EX_Valid}, 32'd1);
    check("areset_pre_stall", {31'd0, Stall}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("areset_stall", {31'd0, Stall}, 32'd0);
    check("areset_valid", {31'd0, EX_Valid}, 32'd0);
    check("areset_ctl", {25'd0, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg, EX_ALUSrc, EX_ALUOp}, 32'd0);
    check("areset_rd1", EX_ReadData1, 32'd0);
    check("areset_rd2", EX_ReadData2, 32'd0);
    check("areset_idx", {17'd0, EX_Rs, EX_Rt, EX_WriteReg}, 32'd0);
    check("areset_cnt", {16'd0, StallCount}, 32'd0);
    check("areset_cnt2", {30'd0, s_StallCount}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    drive(5'd3, 5'd4, 16'hFFF0, 32'h11, 32'h22, 1'b0, 5'd0, 32'h0, 8'b1000_0000, 1'b0);
    @(posedge clock);
    #1;
    check("resume_valid", {31'd0, EX_Valid}, 32'd1);
    check("resume_rd1", EX_ReadData1, 32'h11);
    check("resume_imm", EX_Imm, 32'hFFFFFFF0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
